// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes, FSM states
// and the default datapath width.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIN
   } state_t;

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: AND, OR, or full-adder sum with B inverted when op[2] is set.
module alu_1bit
   import alu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   input  logic [2:0] op_i,
   output logic       res_o,
   output logic       cout_o
);

   logic b_eff;

   always_comb begin
      b_eff  = b_i ^ op_i[2];
      cout_o = (a_i & b_eff) | (a_i & cin_i) | (b_eff & cin_i);
      case (op_i)
         OP_AND:  res_o = a_i & b_i;
         OP_OR:   res_o = a_i | b_i;
         default: res_o = a_i ^ b_eff ^ cin_i;
      endcase
   end

endmodule

// File: rtl/serial_alu32.sv
// Bit-serial ALU: one shared alu_1bit slice processes the operands LSB first,
// one bit per clock, followed by a single-cycle done/FIN state.
module serial_alu32
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d, ovf_q, ovf_d;

   logic             slice_res, slice_cout, msb_ovf;

   alu_1bit u_slice (
      .a_i    (a_q[cnt_q]),
      .b_i    (b_q[cnt_q]),
      .cin_i  (carry_q),
      .op_i   (op_q),
      .res_o  (slice_res),
      .cout_o (slice_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      carry_d = carry_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      msb_ovf = carry_q ^ slice_cout;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               cnt_d   = '0;
               carry_d = op[2];
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            res_d[cnt_q] = slice_res;
            carry_d      = slice_cout;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // Final result and flags are captured on the edge into FIN so
               // they are already stable while done is high.
               cnt_d   = '0;
               state_d = ST_FIN;
               if (op_q == OP_SLT) begin
                  res_d    = '0;
                  res_d[0] = slice_res ^ msb_ovf;
               end
               ovf_d   = (op_q == OP_ADD || op_q == OP_SUB) ? msb_ovf : 1'b0;
               zero_d  = (res_d == '0);
            end
         end
         ST_FIN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_FIN);
   assign result   = res_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu32.sv
// Directed self-checking bench for serial_alu32: arithmetic/logic vectors,
// latency and throughput, start-while-busy, and asynchronous reset abort.
module tb_serial_alu32;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [2:0]  op = '0;
   logic        busy, done, zero, overflow;
   logic [31:0] result;

   int passed = 0;
   int total  = 0;

   serial_alu32 #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .op       (op),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Returns the cycle number (edge count + 1) in which done is first seen, 0 on timeout.
   task automatic wait_done(output int cyc);
      bit seen;
      cyc  = 0;
      seen = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            cyc  = i + 1;
            seen = 1;
         end
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int cyc);
      for (int i = 0; i < 40 && busy; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      a = x; b = y; op = o; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~x; b = ~y; op = OP_AND;
      wait_done(cyc);
   endtask

   int cyc, dones, first, second;
   logic [31:0] res_first, res_second;

   initial begin
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk); rst = 1'b0;

      run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, cyc);
      check("add_ovf_latency", 32'(cyc), 32'd33);
      check("add_ovf_result", result, 32'h8000_0000);
      check("add_ovf_flag", 32'(overflow), 32'd1);
      check("add_ovf_zero", 32'(zero), 32'd0);
      check("add_ovf_busy_in_fin", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("after_fin_done", 32'(done), 32'd0);
      check("after_fin_busy", 32'(busy), 32'd0);
      check("after_fin_hold", result, 32'h8000_0000);

      run_op(OP_SUB, 32'h0000_0005, 32'h0000_0005, cyc);
      check("sub_eq_result", result, 32'h0);
      check("sub_eq_zero", 32'(zero), 32'd1);
      check("sub_eq_ovf", 32'(overflow), 32'd0);

      run_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, cyc);
      check("sub_ovf_result", result, 32'h7FFF_FFFF);
      check("sub_ovf_flag", 32'(overflow), 32'd1);

      run_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, cyc);
      check("slt_neg_pos", result, 32'h0000_0001);
      check("slt_ovf_zero", 32'(overflow), 32'd0);
      check("slt_nonzero", 32'(zero), 32'd0);
      run_op(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, cyc);
      check("slt_pos_neg", result, 32'h0000_0000);
      check("slt_zero_flag", 32'(zero), 32'd1);
      run_op(OP_SLT, 32'h8000_0000, 32'h0000_0001, cyc);
      check("slt_min_ovf", result, 32'h0000_0001);
      check("slt_min_ovf_flag", 32'(overflow), 32'd0);

      run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, cyc);
      check("and_result", result, 32'hF000_F000);
      check("and_ovf", 32'(overflow), 32'd0);
      run_op(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, cyc);
      check("or_result", result, 32'hFFF0_FFF0);
      check("or_ovf", 32'(overflow), 32'd0);

      run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, cyc);
      check("add_wrap_result", result, 32'h0);
      check("add_wrap_zero", 32'(zero), 32'd1);
      check("add_wrap_ovf", 32'(overflow), 32'd0);
      run_op(OP_ADD, 32'h0000_0003, 32'h0000_0004, cyc);
      check("add_fresh_carry", result, 32'h0000_0007);

      // Start ignored mid-run, then back-to-back accept in the IDLE cycle after FIN.
      @(posedge clk); #1;
      @(negedge clk);
      a = 32'd1; b = 32'd2; op = OP_ADD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0; first = 0; second = 0; res_first = '0; res_second = '0;
      for (int i = 1; i <= 80; i++) begin
         start = 1'b0;
         if (i == 10) begin
            start = 1'b1; a = 32'd100; b = 32'd100; op = OP_OR;
         end
         if (first != 0 && i == first + 2) begin
            start = 1'b1; a = 32'd10; b = 32'd20; op = OP_ADD;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done === 1'b1) begin
            dones++;
            if (first == 0) begin
               first = i; res_first = result;
            end else if (second == 0) begin
               second = i; res_second = result;
            end
         end
      end
      check("b2b_first_cycle", 32'(first + 1), 32'd33);
      check("b2b_first_result", res_first, 32'd3);
      check("b2b_done_count", 32'(dones), 32'd2);
      check("b2b_gap", 32'(second - first), 32'd34);
      check("b2b_second_result", res_second, 32'd30);

      // Asynchronous reset in cycle 15 of an operation.
      @(negedge clk);
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = OP_ADD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #3;
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_result", result, 32'h0);
      check("async_rst_done", 32'(done), 32'd0);
      a = 32'd3; b = 32'd4; op = OP_ADD; start = 1'b1;
      @(posedge clk); #1;
      check("start_blocked_in_rst", 32'(busy), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("accept_after_rst", 32'(busy), 32'd1);
      wait_done(cyc);
      check("post_rst_latency", 32'(cyc), 32'd33);
      check("post_rst_result", result, 32'h0000_0007);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
